row_fetch_scheduler: RTL and testbench

ROW_FETCH_SCHEDULER -- requirements
Module: row_fetch_scheduler

---
 rtl/voxel_pkg.sv | 24 ++
 rtl/row_fifo.sv | 53 +++++
 rtl/row_fetch_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_row_fetch_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/voxel_pkg.sv
// Shared types and width helpers for the row fetch scheduler.
package voxel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_e;

  function automatic int row_w(input int img_height);
    return $clog2(img_height);
  endfunction

  function automatic int word_w(input int row_words);
    return $clog2(row_words);
  endfunction

  // Address = {buffer, row, word}
  function automatic int addr_w(input int img_height, input int row_words);
    return 1 + row_w(img_height) + word_w(row_words);
  endfunction

endpackage

// File: rtl/row_fifo.sv
// Read-data FIFO between the memory return path and the LED driver.
module row_fifo #(
  parameter  int DATA_W     = 32,
  parameter  int FIFO_DEPTH = 4,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage is not reset; the head is masked by the consumer while empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/row_fetch_scheduler.sv
// Fetches one display row per rowChange into a small FIFO feeding the LED driver,
// with double-buffer swap on index. ROWFETCH_STATS_EN adds a saturating overrunCnt.
module row_fetch_scheduler
  import voxel_pkg::*;
#(
  parameter  int IMG_HEIGHT = 64,
  parameter  int ROW_WORDS  = 8,
  parameter  int DATA_W     = 32,
  parameter  int FIFO_DEPTH = 4,
  localparam int ROW_W      = row_w(IMG_HEIGHT),
  localparam int WORD_W     = word_w(ROW_WORDS),
  localparam int ADDR_W     = addr_w(IMG_HEIGHT, ROW_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ROW_W-1:0]  row,
  input  logic              valid,
  input  logic              index,
  input  logic              rowChange,
  output logic              rowChangeAck,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memGnt,
  input  logic              memRdValid,
  input  logic [DATA_W-1:0] memRdData,
  output logic [DATA_W-1:0] pixData,
  output logic              pixValid,
  input  logic              pixReady,
  output logic              rowDone,
  output logic              overrun,
  input  logic              swapReq,
  output logic              swapAck,
  output logic              frontBuf
`ifdef ROWFETCH_STATS_EN
  ,
  output logic [15:0]       overrunCnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ROW_W-1:0]  fetchRow_q, fetchRow_d, pendRow_q, pendRow_d;
  logic [WORD_W-1:0] wordIdx_q, wordIdx_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic              fetchBuf_q, fetchBuf_d, pendVld_q, pendVld_d, frontBuf_q, frontBuf_d;
  logic              ack_q, ack_d, ovr_q, ovr_d, swapAck_q, swapAck_d;

  logic [DATA_W-1:0] fifo_dout;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W:0]    inflight;
  logic              fifo_full, fifo_empty;
  logic              busy, abort, rc_new, swap, gnt, ret, push, pop, last_pop;

  assign busy     = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign abort    = busy && !valid;
  // rowChange is still high in the cycle our ack is visible; ignore it there.
  assign rc_new   = rowChange && !ack_q;
  assign swap     = index && swapReq;
  assign inflight = {1'b0, outst_q} + {1'b0, fifo_cnt};

  assign memReq   = !reset && (state_q == ST_ISSUE) && valid && (inflight < (CNT_W+1)'(FIFO_DEPTH));
  assign memAddr  = {fetchBuf_q, fetchRow_q, wordIdx_q};
  assign gnt      = memReq && memGnt;
  // Returns with nothing outstanding belong to a fetch abandoned by reset.
  assign ret      = memRdValid && (outst_q != '0);
  assign push     = ret && busy && !abort && !fifo_full;

  assign pixValid = !fifo_empty;
  assign pixData  = fifo_empty ? '0 : fifo_dout;
  assign pop      = pixValid && pixReady;
  assign last_pop = (state_q == ST_DRAIN) && !abort && pop &&
                    (fifo_cnt == CNT_W'(1)) && (outst_q == '0);

  assign rowDone      = last_pop;
  assign rowChangeAck = ack_q;
  assign overrun      = ovr_q;
  assign swapAck      = swapAck_q;
  assign frontBuf     = frontBuf_q;

  row_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (memRdData),
    .pop   (pop),
    .flush (abort),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_comb begin
    case ({gnt, ret})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase
    frontBuf_d = swap ? ~frontBuf_q : frontBuf_q;
    swapAck_d  = swap;
  end

  always_comb begin
    state_d    = state_q;
    fetchRow_d = fetchRow_q;
    fetchBuf_d = fetchBuf_q;
    wordIdx_d  = wordIdx_q;
    pendVld_d  = pendVld_q;
    pendRow_d  = pendRow_q;
    ack_d      = 1'b0;
    ovr_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // frontBuf_d: a swap in this same cycle applies to the new fetch.
        if (rc_new && valid) begin
          fetchRow_d = row;
          fetchBuf_d = frontBuf_d;
          wordIdx_d  = '0;
          ack_d      = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE, ST_DRAIN: begin
        if (abort) begin
          pendVld_d = 1'b0;
          state_d   = ST_FLUSH;
        end else begin
          if (rc_new) begin
            ack_d     = 1'b1;
            ovr_d     = 1'b1;
            pendVld_d = 1'b1;
            pendRow_d = row;
          end
          if ((state_q == ST_ISSUE) && gnt) begin
            wordIdx_d = wordIdx_q + 1'b1;
            if (wordIdx_q == WORD_W'(ROW_WORDS - 1)) state_d = ST_DRAIN;
          end
          if (last_pop) begin
            if (pendVld_d) begin
              fetchRow_d = pendRow_d;
              fetchBuf_d = frontBuf_d;
              wordIdx_d  = '0;
              pendVld_d  = 1'b0;
              state_d    = ST_ISSUE;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (outst_d == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fetchRow_q <= '0;
      fetchBuf_q <= 1'b0;
      wordIdx_q  <= '0;
      outst_q    <= '0;
      pendVld_q  <= 1'b0;
      pendRow_q  <= '0;
      frontBuf_q <= 1'b0;
      ack_q      <= 1'b0;
      ovr_q      <= 1'b0;
      swapAck_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetchRow_q <= fetchRow_d;
      fetchBuf_q <= fetchBuf_d;
      wordIdx_q  <= wordIdx_d;
      outst_q    <= outst_d;
      pendVld_q  <= pendVld_d;
      pendRow_q  <= pendRow_d;
      frontBuf_q <= frontBuf_d;
      ack_q      <= ack_d;
      ovr_q      <= ovr_d;
      swapAck_q  <= swapAck_d;
    end
  end

`ifdef ROWFETCH_STATS_EN
  logic [15:0] ovrCnt_q;
  always_ff @(posedge clk) begin
    if (reset || index)                   ovrCnt_q <= '0;
    else if (ovr_q && (ovrCnt_q != '1))   ovrCnt_q <= ovrCnt_q + 1'b1;
  end
  assign overrunCnt = ovrCnt_q;
`endif

endmodule

// File: tb/tb_row_fetch_scheduler.sv
// Scoreboard bench: expected addresses/pixels queued when a row is requested,
// checked as grants and pops happen on the bus.
module tb_row_fetch_scheduler;

  logic        clk, reset, valid, index, rowChange, rowChangeAck, memReq, memGnt, memRdValid;
  logic [5:0]  row;
  logic [9:0]  memAddr;
  logic [31:0] memRdData, pixData;
  logic        pixValid, pixReady, rowDone, overrun, swapReq, swapAck, frontBuf;
`ifdef ROWFETCH_STATS_EN
  logic [15:0] overrunCnt;
`endif

  row_fetch_scheduler #(.IMG_HEIGHT(64), .ROW_WORDS(8), .DATA_W(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .row(row), .valid(valid), .index(index),
    .rowChange(rowChange), .rowChangeAck(rowChangeAck), .memReq(memReq), .memAddr(memAddr),
    .memGnt(memGnt), .memRdValid(memRdValid), .memRdData(memRdData), .pixData(pixData),
    .pixValid(pixValid), .pixReady(pixReady), .rowDone(rowDone), .overrun(overrun),
    .swapReq(swapReq), .swapAck(swapAck), .frontBuf(frontBuf)
`ifdef ROWFETCH_STATS_EN
    , .overrunCnt(overrunCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, lat = 2;
  int gnts = 0, pops = 0, rdone = 0, ovrs = 0, acks = 0, swacks = 0;
  int pv_seen = 0, mr_seen = 0, rv_seen = 0;
  bit watch = 0;
  logic        exp_front = 1'b0;
  logic [9:0]  addr_q[$];
  logic [31:0] pix_q[$];
  int          ret_due[$];
  logic [31:0] ret_dat[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [31:0] mword(input logic [9:0] a);
    return {a, 12'hA5C, a};
  endfunction

  function automatic logic [9:0] mk_addr(input logic b, input int r, input int w);
    return {b, 6'(r), 3'(w)};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_row(input int r);
    for (int w = 0; w < 8; w++) begin
      addr_q.push_back(mk_addr(exp_front, r, w));
      pix_q.push_back(mword(mk_addr(exp_front, r, w)));
    end
  endtask

  task automatic drive_row(input int r, input bit fetch, input string tag);
    bit got = 0;
    if (fetch) push_row(r);
    row = 6'(r);
    rowChange = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = rowChangeAck;
    end
    rowChange = 1'b0;
    chk(tag, got, 1);
  endtask

  task automatic wait_rdone(input int target, input string tag);
    for (int i = 0; i < 400 && rdone < target; i++) tick();
    chk(tag, rdone >= target, 1);
  endtask

  // Memory model and bus monitor: returns driven at negedge, sampled before posedge.
  initial begin : bus
    forever begin
      @(negedge clk);
      cyc++;
      if (ret_due.size() != 0 && ret_due[0] <= cyc) begin
        memRdValid = 1'b1;
        memRdData  = ret_dat[0];
        ret_due.delete(0);
        ret_dat.delete(0);
      end else begin
        memRdValid = 1'b0;
        memRdData  = '0;
      end
      #3;
      if (memReq && memGnt) begin
        gnts++;
        if (addr_q.size() == 0) chk("addr_spurious", addr_q.size(), 1);
        else chk("memAddr", memAddr, addr_q.pop_front());
        ret_due.push_back(cyc + lat);
        ret_dat.push_back(mword(memAddr));
      end
      if (pixValid && pixReady) begin
        pops++;
        if (pix_q.size() == 0) chk("pix_spurious", pix_q.size(), 1);
        else chk("pixData", pixData, pix_q.pop_front());
      end
      if (rowDone) rdone++;
      if (overrun) ovrs++;
      if (rowChangeAck) acks++;
      if (swapAck) swacks++;
      if (watch) begin
        if (pixValid) pv_seen++;
        if (memReq) mr_seen++;
        if (memRdValid) rv_seen++;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int g0, d0, a0, o0, p0, s0;
    reset = 1'b1; valid = 1'b1; index = 1'b0; rowChange = 1'b0; row = '0;
    memGnt = 1'b1; memRdValid = 1'b0; memRdData = '0; pixReady = 1'b1; swapReq = 1'b0;
    repeat (3) tick();
    chk("rst_memReq", memReq, 0);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_pixValid", pixValid, 0);
    chk("rst_pixData", pixData, 0);
    chk("rst_pulses", {rowDone, rowChangeAck, overrun, swapAck}, 0);
    chk("rst_frontBuf", frontBuf, 0);
    reset = 1'b0;
    tick();

    // Plain fetch of row 5
    g0 = gnts; d0 = rdone; a0 = acks; p0 = pops;
    drive_row(5, 1, "t1_ack_seen");
    wait_rdone(d0 + 1, "t1_rowdone_seen");
    repeat (3) tick();
    chk("t1_rowdone_cnt", rdone - d0, 1);
    chk("t1_ack_cnt", acks - a0, 1);
    chk("t1_grants", gnts - g0, 8);
    chk("t1_pops", pops - p0, 8);
    chk("t1_pix_left", pix_q.size(), 0);

    // Back-pressure: FIFO plus outstanding caps requests at 4
    pixReady = 1'b0;
    g0 = gnts; d0 = rdone;
    drive_row(5, 1, "t2_ack_seen");
    repeat (20) tick();
    chk("t2_grants_stalled", gnts - g0, 4);
    chk("t2_memReq_low", memReq, 0);
    chk("t2_pixValid", pixValid, 1);
    pixReady = 1'b1;
    wait_rdone(d0 + 1, "t2_rowdone_seen");
    repeat (3) tick();
    chk("t2_grants_total", gnts - g0, 8);
    chk("t2_pix_left", pix_q.size(), 0);

    // Overruns: row 7 superseded by row 8 while row 6 is busy
    pixReady = 1'b0;
    g0 = gnts; d0 = rdone; o0 = ovrs; a0 = acks;
    drive_row(6, 1, "t3_ack6");
    repeat (2) tick();
    drive_row(7, 0, "t3_ack7");
    pixReady = 1'b1;
    for (int i = 0; i < 100 && gnts < g0 + 8; i++) tick();
    chk("t3_row6_grants", gnts - g0, 8);
    pixReady = 1'b0;
    drive_row(8, 1, "t3_ack8");
    pixReady = 1'b1;
    wait_rdone(d0 + 2, "t3_rowdone_seen");
    repeat (3) tick();
    chk("t3_overruns", ovrs - o0, 2);
    chk("t3_acks", acks - a0, 3);
    chk("t3_rowdones", rdone - d0, 2);
    chk("t3_grants", gnts - g0, 16);
    chk("t3_addr_left", addr_q.size(), 0);

    // Buffer swap rules
    s0 = swacks;
    swapReq = 1'b1;
    repeat (3) tick();
    chk("t4_no_index_front", frontBuf, 0);
    swapReq = 1'b0; index = 1'b1;
    tick();
    index = 1'b0;
    repeat (2) tick();
    chk("t4_no_req_front", frontBuf, 0);
    chk("t4_no_req_ack", swacks - s0, 0);
    g0 = gnts; d0 = rdone;
    swapReq = 1'b1;
    drive_row(3, 1, "t4_ack3");
    for (int i = 0; i < 50 && gnts < g0 + 2; i++) tick();
    index = 1'b1;
    tick();
    index = 1'b0; swapReq = 1'b0; exp_front = 1'b1;
    chk("t4_swapAck", swapAck, 1);
    chk("t4_front_toggled", frontBuf, 1);
    tick();
    chk("t4_swapAck_width", swapAck, 0);
    wait_rdone(d0 + 1, "t4_row3_done");
    d0 = rdone;
    drive_row(9, 1, "t4_ack9");
    wait_rdone(d0 + 1, "t4_row9_done");
    tick();
    // Swap and row change in the same cycle: fetch uses the new buffer
    d0 = rdone;
    exp_front = ~exp_front;
    push_row(12);
    row = 6'd12; rowChange = 1'b1; swapReq = 1'b1; index = 1'b1;
    tick();
    index = 1'b0; swapReq = 1'b0;
    chk("t4_sim_ack", rowChangeAck, 1);
    rowChange = 1'b0;
    chk("t4_sim_front", frontBuf, 0);
    wait_rdone(d0 + 1, "t4_row12_done");
    repeat (2) tick();
    chk("t4_addr_left", addr_q.size(), 0);

    // Lock lost with 3 reads in flight
    lat = 20;
    g0 = gnts; d0 = rdone;
    drive_row(10, 1, "t5_ack10");
    for (int i = 0; i < 50 && gnts < g0 + 3; i++) tick();
    valid = 1'b0; watch = 1'b1;
    addr_q.delete();
    pix_q.delete();
    for (int i = 0; i < 60 && ret_due.size() != 0; i++) tick();
    repeat (2) tick();
    watch = 1'b0;
    chk("t5_grants", gnts - g0, 3);
    chk("t5_memReq_after", mr_seen, 0);
    chk("t5_pixValid_after", pv_seen, 0);
    chk("t5_returns", rv_seen, 3);
    chk("t5_no_rowdone", rdone - d0, 0);
    lat = 2; valid = 1'b1;
    tick();
    // Back in IDLE: a new request is taken, with an irregular grant pattern
    d0 = rdone;
    drive_row(11, 1, "t5_ack11");
    for (int i = 0; i < 300 && rdone < d0 + 1; i++) begin
      memGnt = 1'($urandom_range(0, 1));
      tick();
    end
    memGnt = 1'b1;
    chk("t5_row11_done", rdone - d0, 1);
    repeat (3) tick();
    chk("t5_pix_left", pix_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
